// File: rtl/bcd_pkg.sv
// Shared BCD definitions: converter FSM states, nibble width and the
// leading-zero blank mask used by this converter and the display drivers.
package bcd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int BCD_NIBBLE_W = 4;
  localparam int MAX_DIGITS   = 8;
  localparam int BCD_MAX_W    = BCD_NIBBLE_W * MAX_DIGITS;

  // Bit i is set when i > 0 and every digit from i up to the top is zero,
  // so a value always shows at least its ones digit.
  function automatic logic [MAX_DIGITS-1:0] blank_mask(
    input logic [BCD_MAX_W-1:0] bcd,
    input int                   digits
  );
    logic [MAX_DIGITS-1:0] m;
    logic                  zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      if (i < digits) begin
        zero_above = zero_above && (bcd[BCD_NIBBLE_W*i +: BCD_NIBBLE_W] == '0);
        m[i]       = zero_above;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] d_i,
  output logic [BCD_NIBBLE_W-1:0] q_o
);

  assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock,
// with held packed-BCD outputs and a leading-zero blank mask.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BIN_W-1:0]           in_value,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] out_bcd,
  output logic [DIGITS-1:0]          out_blank,
  output logic                       out_valid,
  output logic                       busy
);

  localparam int ACC_W = BCD_NIBBLE_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [DIGITS-1:0] BLANK_RST = DIGITS'(blank_mask('0, DIGITS));

  if ((DIGITS > MAX_DIGITS) || (10**DIGITS < 2**BIN_W)) begin : g_param_check
    $error("bin_to_bcd_seq: DIGITS=%0d cannot hold BIN_W=%0d", DIGITS, BIN_W);
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [ACC_W-1:0]  out_bcd_q, out_bcd_d;
  logic [DIGITS-1:0] out_blank_q, out_blank_d;
  logic              out_valid_q, out_valid_d;

  logic [ACC_W-1:0]  acc_corr;
  logic [ACC_W-1:0]  acc_shl;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (acc_q[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .q_o (acc_corr[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  // Corrected accumulator shifted left, pulling in the next binary MSB.
  assign acc_shl = {acc_corr[ACC_W-2:0], bin_q[BIN_W-1]};

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHIFT);
  assign out_bcd   = out_bcd_q;
  assign out_blank = out_blank_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    bin_d       = bin_q;
    out_bcd_d   = out_bcd_q;
    out_blank_d = out_blank_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          bin_d   = in_value;
          acc_d   = '0;
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = acc_shl;
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cnt_d       = '0;
          out_bcd_d   = acc_shl;
          out_blank_d = DIGITS'(blank_mask(BCD_MAX_W'(acc_shl), DIGITS));
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      bin_q       <= '0;
      out_bcd_q   <= '0;
      out_blank_q <= BLANK_RST;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      bin_q       <= bin_d;
      out_bcd_q   <= out_bcd_d;
      out_blank_q <= out_blank_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised self-checking bench for bin_to_bcd_seq: default 8-bit/3-digit
// instance plus a 10-bit/4-digit instance, checked against a decimal model.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, busy;
  logic [7:0]  in_value;
  logic [11:0] out_bcd;
  logic [2:0]  out_blank;

  logic        w_valid, w_ready, w_out_valid, w_busy;
  logic [9:0]  w_value;
  logic [15:0] w_bcd;
  logic [3:0]  w_blank;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .out_bcd(out_bcd), .out_blank(out_blank),
    .out_valid(out_valid), .busy(busy)
  );

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_ready),
    .in_value(w_value), .out_bcd(w_bcd), .out_blank(w_blank),
    .out_valid(w_out_valid), .busy(w_busy)
  );

  int  n_chk  = 0;
  int  n_pass = 0;
  time t_vld  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Decimal digits by repeated division, independent of any shift algorithm.
  function automatic logic [31:0] ref_bcd(input int v, input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit i is a leading zero when the value is below 10**i.
  function automatic logic [31:0] ref_blank(input int v, input int d);
    logic [31:0] r = '0;
    int p = 10;
    for (int i = 1; i < d; i++) begin
      r[i] = (v < p);
      p = p * 10;
    end
    return r;
  endfunction

  // Drives one accept, then waits (bounded) for out_valid and checks latency,
  // busy duration and result. Returns #1 after the edge that raised out_valid.
  task automatic conv(input int v, input bit wide, input bit noisy, input string tag);
    int cyc = 0, bsy = 0, lat, dig;
    bit vld = 1'b0;
    lat = wide ? 10 : 8;
    dig = wide ? 4 : 3;
    chk({tag, "_ready"}, 32'(wide ? w_ready : in_ready), 32'd1);
    if (wide) begin w_valid = 1'b1; w_value = 10'(v); end
    else      begin in_valid = 1'b1; in_value = 8'(v); end
    @(posedge clk); #1;
    w_valid  = 1'b0;
    in_valid = 1'b0;
    bsy = wide ? int'(w_busy) : int'(busy);
    while (cyc < 40 && !vld) begin
      @(posedge clk); #1;
      cyc++;
      vld = wide ? w_out_valid : out_valid;
      bsy += wide ? int'(w_busy) : int'(busy);
      if (noisy && !vld) begin
        in_valid = 1'b1;
        in_value = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    t_vld = $time;
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_busy_cycles"}, 32'(bsy), 32'(lat));
    chk({tag, "_bcd"}, 32'(wide ? w_bcd : 16'(out_bcd)), ref_bcd(v, dig));
    chk({tag, "_blank"}, 32'(wide ? w_blank : 4'(out_blank)), ref_blank(v, dig));
  endtask

  initial begin
    time t_first;
    bit  seen;
    rst_n = 1'b0; in_valid = 1'b0; in_value = '0; w_valid = 1'b0; w_value = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bcd",   32'(out_bcd),   32'h000);
    chk("reset_blank", 32'(out_blank), 32'b110);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_ready", 32'(in_ready),  32'd1);
    chk("reset_busy",  32'(busy),      32'd0);

    conv(37, 1'b0, 1'b0, "d37");
    @(posedge clk); #1;
    chk("d37_pulse", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("d37_held", 32'(out_bcd), 32'h037);

    conv(128, 1'b0, 1'b0, "d128");
    @(posedge clk); #1;
    conv(255, 1'b0, 1'b0, "d255");
    @(posedge clk); #1;

    conv(9, 1'b0, 1'b0, "b2b9");
    t_first = t_vld;
    conv(100, 1'b0, 1'b0, "b2b100");
    chk("b2b_spacing", 32'((t_vld - t_first) / 10), 32'd9);
    @(posedge clk); #1;

    conv(200, 1'b0, 1'b1, "noisy200");
    @(posedge clk); #1;
    conv(3, 1'b0, 1'b1, "noisy3");
    @(posedge clk); #1;

    for (int k = 0; k < 16; k++) begin
      conv(int'($urandom_range(0, 255)), 1'b0, ($urandom_range(0, 1) == 1), "rnd");
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
    conv(0, 1'b0, 1'b0, "d0");
    @(posedge clk); #1;

    // Abort a conversion of 64 part way through.
    in_valid = 1'b1; in_value = 8'd64;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_bcd",   32'(out_bcd),   32'h000);
    chk("abort_blank", 32'(out_blank), 32'b110);
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_ready", 32'(in_ready),  32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);
    chk("abort_held_bcd", 32'(out_bcd), 32'h000);
    conv(64, 1'b0, 1'b0, "reacc64");
    @(posedge clk); #1;

    conv(1023, 1'b1, 1'b0, "w1023");
    @(posedge clk); #1;
    conv(7, 1'b1, 1'b0, "w7");
    for (int k = 0; k < 4; k++) begin
      conv(int'($urandom_range(0, 1023)), 1'b1, 1'b0, "wrnd");
    end
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_chk);
    $fatal(1);
  end

endmodule
